fetch_stage: RTL and testbench

//  IF stage of the pipelined RV32 core; directly upstream of the decode stage.

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction fetch stage with credit-limited imem requests and response buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        valid_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_word_q [FIFO_DEPTH];
  logic [31:0]   buf_word_d [FIFO_DEPTH];
  logic [31:0]   buf_pc_q   [FIFO_DEPTH];
  logic [31:0]   buf_pc_d   [FIFO_DEPTH];
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pc_plus_4_q, pc_plus_4_d;
  logic          valid_q, valid_d;

  logic [CW:0]   used;
  logic [CW-1:0] live_cnt;
  logic [31:0]   resp_pc;
  logic          req_fire;
  logic          resp_keep;
  logic          pop;

  // Credits cover both outstanding requests and buffered words, so a push can never overflow.
  assign used           = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !reset && !redirect_valid && (used < DEPTH_C);
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Live requests were issued back-to-back since the last redirect, so the oldest sits 4*live below fpc.
  assign live_cnt  = inflight_q - drop_cnt_q;
  assign resp_pc   = fpc_q - {{(30 - CW){1'b0}}, live_cnt, 2'b00};
  assign resp_keep = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign pop       = !redirect_valid && EN && (count_q != '0);

  always_comb begin
    fpc_d       = fpc_q;
    inflight_d  = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_cnt_d  = drop_cnt_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_word_d  = buf_word_q;
    buf_pc_d    = buf_pc_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    pc_plus_4_d = pc_plus_4_q;
    valid_d     = valid_q;

    if (redirect_valid) begin
      fpc_d      = redirect_pc;
      drop_cnt_d = inflight_q - CW'(imem_resp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      instr_d    = NOP;
      valid_d    = 1'b0;
    end else begin
      if (req_fire) begin
        fpc_d = fpc_q + 32'd4;
      end
      if (imem_resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (resp_keep) begin
        buf_word_d[wr_ptr_q] = imem_resp_data;
        buf_pc_d[wr_ptr_q]   = resp_pc;
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        instr_d     = buf_word_q[rd_ptr_q];
        pc_d        = buf_pc_q[rd_ptr_q];
        pc_plus_4_d = buf_pc_q[rd_ptr_q] + 32'd4;
        valid_d     = 1'b1;
        rd_ptr_d    = rd_ptr_q + AW'(1);
      end else if (EN) begin
        instr_d = NOP;
        valid_d = 1'b0;
      end
      count_d = count_q + CW'(resp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q       <= RESET_PC;
      inflight_q  <= '0;
      drop_cnt_q  <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      instr_q     <= NOP;
      pc_q        <= 32'd0;
      pc_plus_4_q <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      fpc_q       <= fpc_d;
      inflight_q  <= inflight_d;
      drop_cnt_q  <= drop_cnt_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      pc_plus_4_q <= pc_plus_4_d;
      valid_q     <= valid_d;
    end
  end

  // Buffer storage carries no reset; occupancy is governed entirely by count/pointers.
  always_ff @(posedge clk) begin
    buf_word_q <= buf_word_d;
    buf_pc_q   <= buf_pc_d;
  end

  assign Instr     = instr_q;
  assign PC        = pc_q;
  assign PC_plus_4 = pc_plus_4_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a queue-based model
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, EN, redirect_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] redirect_pc, imem_resp_data;
  logic        imem_req_valid, valid_out;
  logic [31:0] imem_req_addr, Instr, PC, PC_plus_4;
  logic        w_req_valid, w_valid_out;
  logic [31:0] w_req_addr, w_instr, w_pc, w_pc4;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .EN(EN),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .Instr(Instr), .PC(PC), .PC_plus_4(PC_plus_4), .valid_out(valid_out)
  );

  // Same handshakes as dut, but starting 8 bytes below zero to exercise address wrap.
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH), .NOP(NOP)) dut_w (
    .clk(clk), .reset(reset), .EN(EN),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .Instr(w_instr), .PC(w_pc), .PC_plus_4(w_pc4), .valid_out(w_valid_out)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];
  logic [31:0] buf_pc[$];
  logic [31:0] next_addr, e_instr, e_pc, e_pc4;
  logic        e_valid;
  int          cyc, lat, delivered;
  int          total, bad;
  bit          w_chk, seen_fffc, seen_zero;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9601;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; EN = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    @(posedge clk); #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    pend.delete(); buf_pc.delete();
    next_addr = 32'd0; e_instr = NOP; e_pc = 32'd0; e_pc4 = 32'd0; e_valid = 1'b0;
    chk("rst_instr", Instr, NOP);
    chk("rst_pc", PC, 32'd0);
    chk("rst_pc4", PC_plus_4, 32'd0);
    chk("rst_valid", valid_out, 1'b0);
  endtask

  task automatic cycle(input bit en, input bit rdy, input bit redir,
                       input logic [31:0] rpc, input bit allow_resp);
    bit          acc, rsp, keep;
    req_t        r;
    logic [31:0] p, acc_addr;
    EN = en; imem_req_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    rsp = allow_resp && (pend.size() != 0) && (cyc >= pend[0].due);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
    #1;
    chk("req_valid", imem_req_valid, !redir && ((pend.size() + buf_pc.size()) < DEPTH));
    if (imem_req_valid) chk("req_addr", imem_req_addr, next_addr);
    if (w_chk) begin
      chk("w_req_valid", w_req_valid, imem_req_valid);
      if (w_req_valid) chk("w_req_addr", w_req_addr, next_addr - 32'd8);
    end
    acc      = imem_req_valid && rdy;
    acc_addr = imem_req_addr;
    @(posedge clk); #1;
    cyc++;
    keep = 1'b0;
    if (rsp) begin
      r    = pend.pop_front();
      keep = !r.stale && !redir;
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      buf_pc.delete();
      e_instr = NOP; e_valid = 1'b0; next_addr = rpc;
    end else if (en) begin
      if (buf_pc.size() != 0) begin
        p = buf_pc.pop_front();
        e_instr = mem_word(p); e_pc = p; e_pc4 = p + 32'd4; e_valid = 1'b1;
        delivered++;
      end else begin
        e_instr = NOP; e_valid = 1'b0;
      end
    end
    if (keep) buf_pc.push_back(r.addr);
    if (acc) begin
      pend.push_back('{acc_addr, cyc + lat - 1, 1'b0});
      next_addr = next_addr + 32'd4;
    end
    chk("instr", Instr, e_instr);
    chk("valid_out", valid_out, e_valid);
    chk("pc", PC, e_pc);
    chk("pc_plus_4", PC_plus_4, e_pc4);
    if (w_chk) begin
      chk("w_valid_out", w_valid_out, e_valid);
      if (e_valid) begin
        chk("w_instr", w_instr, e_instr);
        chk("w_pc", w_pc, e_pc - 32'd8);
        chk("w_pc4", w_pc4, e_pc4 - 32'd8);
        if (w_pc == 32'hFFFF_FFFC && w_pc4 == 32'd0) seen_fffc = 1'b1;
        if (w_pc == 32'd0 && w_pc4 == 32'd4) seen_zero = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] held_addr;
    bit          found;
    total = 0; bad = 0; cyc = 0; lat = 1; delivered = 0;
    w_chk = 1'b0; seen_fffc = 1'b0; seen_zero = 1'b0;

    // 1: one-cycle memory, EN=1; first real instruction on the 3rd cycle
    do_reset();
    repeat (3) cycle(1, 1, 0, 32'd0, 1);
    chk("t1_first_valid", valid_out, 1'b1);
    chk("t1_first_pc", PC, 32'd0);
    chk("t1_first_instr", Instr, mem_word(32'd0));
    repeat (7) cycle(1, 1, 0, 32'd0, 1);

    // 2: decode stall for 5 cycles
    repeat (5) cycle(0, 1, 0, 32'd0, 1);
    chk("t2_req_stopped", imem_req_valid, 1'b0);
    repeat (6) cycle(1, 1, 0, 32'd0, 1);

    // 3: redirect to 0x100 with two requests in flight
    do_reset();
    lat = 2;
    repeat (2) cycle(1, 1, 0, 32'd0, 1);
    cycle(1, 1, 1, 32'h0000_0100, 0);
    chk("t3_bubble_instr", Instr, NOP);
    chk("t3_bubble_valid", valid_out, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1, 1, 0, 32'd0, 1);
      if (valid_out) begin
        found = 1'b1;
        chk("t3_first_pc", PC, 32'h0000_0100);
      end
    end
    chk("t3_found_valid", found, 1'b1);

    // 4: memory not ready for 3 cycles
    lat = 1;
    repeat (6) cycle(1, 1, 0, 32'd0, 1);
    held_addr = imem_req_addr;
    repeat (3) begin
      cycle(1, 0, 0, 32'd0, 1);
      chk("t4_addr_stable", imem_req_addr, held_addr);
    end
    chk("t4_bubble", valid_out, 1'b0);
    repeat (4) cycle(1, 1, 0, 32'd0, 1);

    // 5: redirect coinciding with a response while EN=0
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (pend.size() != 0 && cyc >= pend[0].due && valid_out) found = 1'b1;
      else cycle(1, 1, 0, 32'd0, 1);
    end
    chk("t5_setup", found, 1'b1);
    cycle(0, 1, 1, 32'h0000_0200, 1);
    chk("t5_bubble_instr", Instr, NOP);
    chk("t5_bubble_valid", valid_out, 1'b0);
    repeat (8) cycle(1, 1, 0, 32'd0, 1);

    // 6: wrapping fetch PC on the second instance
    do_reset();
    chk("t6_first_addr", w_req_addr, 32'hFFFF_FFF8);
    w_chk = 1'b1;
    repeat (14) cycle(1, 1, 0, 32'd0, 1);
    chk("t6_seen_fffc_wrap", seen_fffc, 1'b1);
    chk("t6_seen_zero", seen_zero, 1'b1);
    w_chk = 1'b0;

    // randomized stalls, back-pressure, latency and redirects
    do_reset();
    delivered = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 3);
      cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 25) == 0,
            {$urandom, 2'b00} , ($urandom % 5) != 0);
    end
    chk("rand_progress", delivered > 200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
